// File: rtl/mem_pkg.sv
// mem_pkg: shared constants and types for the banked memory responder.
package mem_pkg;

   localparam int unsigned BANK_CNT = 4;

   typedef logic [1:0] bank_t;
   typedef logic [3:0] lat_cnt_t;

   typedef enum logic {PK_RD, PK_WR} pend_kind_t;

endpackage

// File: rtl/mem_bank.sv
// mem_bank: one memory bank with its storage array, a latency down-counter
// and a single pending slot that holds the kind and the captured read data.
module mem_bank
   import mem_pkg::*;
#(
   parameter int unsigned BANK_LAT = 4,
   parameter int unsigned INDEX_W  = 11
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               acc,       // accept this cycle, already masked by rst
   input  logic               isWr,
   input  logic [INDEX_W-1:0] index,
   input  logic [15:0]        wrData,
   output logic               busy,
   output logic               cmpl,      // counter goes 1->0 at the coming edge
   output logic [15:0]        cmplData
);

   logic [15:0] storage [2**INDEX_W];
   lat_cnt_t    cntQ, cntD;
   pend_kind_t  kindQ;
   logic [15:0] retQ;

   // Storage write at the accept edge; contents survive reset.
   always_ff @(posedge clk) begin
      if (acc && isWr) begin
         storage[index] <= wrData;
      end
   end

   // Latency counter: load on accept, count down to zero otherwise.
   always_comb begin
      cntD = cntQ;
      if (acc) begin
         cntD = lat_cnt_t'(BANK_LAT - 1);
      end else if (cntQ != '0) begin
         cntD = cntQ - lat_cnt_t'(1);
      end
   end

   // Counter and pending slot registers; reset drops any in-flight access.
   always_ff @(posedge clk) begin
      if (rst) begin
         cntQ  <= '0;
         kindQ <= PK_RD;
         retQ  <= '0;
      end else begin
         cntQ <= cntD;
         if (acc) begin
            kindQ <= isWr ? PK_WR : PK_RD;
            retQ  <= isWr ? 16'h0000 : storage[index];
         end
      end
   end

   assign busy     = (cntQ != '0);
   assign cmpl     = (cntQ == lat_cnt_t'(1));
   assign cmplData = (kindQ == PK_RD) ? retQ : 16'h0000;

endmodule

// File: rtl/banked_mem_responder.sv
// banked_mem_responder: four-bank word memory answering Rd/Wr requests with
// Stall, per-bank Busy and a delayed one-cycle Done/DataOut.
// Optional feature macro: MEM_ALIGN_CHECK_EN (odd address or Rd&Wr flagged on Err).
module banked_mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned BANK_LAT = 4,
   parameter int unsigned INDEX_W  = 11
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        Rd,
   input  logic        Wr,
   input  logic [15:0] Addr,
   input  logic [15:0] DataIn,
   output logic [15:0] DataOut,
   output logic        Done,
   output logic        Stall,
   output logic [3:0]  Busy,
   output logic        Err
);

   bank_t               bank;
   logic [INDEX_W-1:0]  index;
   logic                req;
   logic                illegal;
   logic                acc;
   logic [BANK_CNT-1:0] bankAcc;
   logic [BANK_CNT-1:0] bankCmpl;
   logic [15:0]         bankData [BANK_CNT];
   logic                anyCmpl;
   logic [15:0]         muxData;
   logic                doneQ;
   logic [15:0]         dataOutQ;

   // Address bits outside bank/index (and bit 0 in the default build) are don't-care.
   logic unusedAddr;
   assign unusedAddr = ^Addr;

   assign bank  = Addr[2:1];
   assign index = Addr[INDEX_W+2:3];
   assign req   = Rd ^ Wr;

`ifdef MEM_ALIGN_CHECK_EN
   assign illegal = (Rd | Wr) & (Addr[0] | (Rd & Wr));
`else
   assign illegal = 1'b0;
`endif

   assign Stall = req & Busy[bank] & ~illegal;
   assign acc   = req & ~Busy[bank] & ~illegal & ~rst;

   // Steer the accept to the addressed bank.
   always_comb begin
      bankAcc = '0;
      for (int b = 0; b < BANK_CNT; b++) begin
         bankAcc[b] = acc & (bank == bank_t'(b));
      end
   end

   for (genvar b = 0; b < BANK_CNT; b++) begin : genBank
      mem_bank #(
         .BANK_LAT(BANK_LAT),
         .INDEX_W (INDEX_W)
      ) uBank (
         .clk     (clk),
         .rst     (rst),
         .acc     (bankAcc[b]),
         .isWr    (Wr),
         .index   (index),
         .wrData  (DataIn),
         .busy    (Busy[b]),
         .cmpl    (bankCmpl[b]),
         .cmplData(bankData[b])
      );
   end

   // Completion mux; fixed latency and one accept per cycle keep this one-hot.
   always_comb begin
      anyCmpl = 1'b0;
      muxData = '0;
      for (int b = 0; b < BANK_CNT; b++) begin
         if (bankCmpl[b]) begin
            anyCmpl = 1'b1;
            muxData = bankData[b];
         end
      end
   end

   // Registered Done/DataOut from the completing bank.
   always_ff @(posedge clk) begin
      if (rst) begin
         doneQ    <= 1'b0;
         dataOutQ <= '0;
      end else begin
         doneQ    <= anyCmpl;
         dataOutQ <= anyCmpl ? muxData : 16'h0000;
      end
   end

   assign Done    = doneQ;
   assign DataOut = dataOutQ;

`ifdef MEM_ALIGN_CHECK_EN
   logic errQ;

   // Err pulses for the cycle after an illegal request.
   always_ff @(posedge clk) begin
      if (rst) begin
         errQ <= 1'b0;
      end else begin
         errQ <= illegal;
      end
   end

   assign Err = errQ;
`else
   assign Err = 1'b0;
`endif

endmodule

// File: tb/tb_banked_mem_responder.sv
// tb_banked_mem_responder: directed and random requests against a timestamp model.
module tb_banked_mem_responder;

   localparam int LAT  = 4;
   localparam int LAT2 = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd = 1'b0, wr = 1'b0;
   logic [15:0] addr = '0, din = '0;
   logic [15:0] dataOut;
   logic        done, stall, err;
   logic [3:0]  busy;

   logic        rd2 = 1'b0, wr2 = 1'b0;
   logic [15:0] addr2 = '0, din2 = '0;
   logic [15:0] dataOut2;
   logic        done2, stall2, err2;
   logic [3:0]  busy2;

   int nVec = 0;
   int nMis = 0;

   // Reference model: word storage, cycle at which each bank frees up,
   // and the expected DataOut keyed by the cycle its Done appears.
   int          k;
   logic [15:0] mem [int];
   int          bankFree [4];
   logic [15:0] doneAt [int];
   logic        errPend;
   logic        accepted;
   logic        lastStall;

   banked_mem_responder #(.BANK_LAT(LAT), .INDEX_W(11)) dut (
      .clk(clk), .rst(rst), .Rd(rd), .Wr(wr), .Addr(addr), .DataIn(din),
      .DataOut(dataOut), .Done(done), .Stall(stall), .Busy(busy), .Err(err)
   );

   banked_mem_responder #(.BANK_LAT(LAT2), .INDEX_W(11)) dut2 (
      .clk(clk), .rst(rst), .Rd(rd2), .Wr(wr2), .Addr(addr2), .DataIn(din2),
      .DataOut(dataOut2), .Done(done2), .Stall(stall2), .Busy(busy2), .Err(err2)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      nVec++;
      assert (obs === expv) else begin
         nMis++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
      end
   endtask

   task automatic drive(input logic r, input logic w, input logic [15:0] a,
                        input logic [15:0] d, input logic rs);
      rd = r; wr = w; addr = a; din = d; rst = rs;
   endtask

   // Compare the main DUT with the model for the current cycle, then advance the model.
   task automatic sampleMain(output logic acc);
      logic [1:0]  b;
      int          key;
      logic [3:0]  eBusy;
      logic        req, ill, eStall, eDone;
      logic [15:0] eData;
      int          late [$];
      b   = addr[2:1];
      key = int'(addr[13:1]);
      for (int i = 0; i < 4; i++) eBusy[i] = (k < bankFree[i]);
      req = rd ^ wr;
`ifdef MEM_ALIGN_CHECK_EN
      ill = (rd | wr) & (addr[0] | (rd & wr));
`else
      ill = 1'b0;
`endif
      eStall = req & eBusy[b] & ~ill;
      eDone  = doneAt.exists(k);
      eData  = eDone ? doneAt[k] : 16'h0000;
      check("busy",    16'(busy),  16'(eBusy));
      check("stall",   16'(stall), 16'(eStall));
      check("done",    16'(done),  16'(eDone));
      check("dataOut", dataOut,    eData);
      check("err",     16'(err),   16'(errPend));
      acc = req & ~eBusy[b] & ~ill & ~rst;
      if (acc) begin
         if (wr) begin
            mem[key] = din;
            doneAt[k + LAT] = 16'h0000;
         end else begin
            doneAt[k + LAT] = mem.exists(key) ? mem[key] : 16'h0000;
         end
         bankFree[b] = k + LAT;
      end
      errPend = ill & ~rst;
      if (rst) begin
         foreach (doneAt[c]) if (c > k) late.push_back(c);
         foreach (late[i]) doneAt.delete(late[i]);
         for (int i = 0; i < 4; i++) bankFree[i] = 0;
      end
      if (doneAt.exists(k)) doneAt.delete(k);
      lastStall = eStall;
      k++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic endCycle();
      sampleMain(accepted);
      tick();
   endtask

   task automatic step(input logic r, input logic w, input logic [15:0] a,
                       input logic [15:0] d, input logic rs);
      drive(r, w, a, d, rs);
      #3;
      endCycle();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
   endtask

   // Present a request and hold it until the model says it was accepted.
   task automatic issue(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
      int n;
      n = 0;
      do begin
         step(r, w, a, d, 1'b0);
         n++;
      end while (!accepted && n < 20);
      check("issue_accepted", 16'(accepted), 16'h0001);
   endtask

   // One cycle on the BANK_LAT=2 instance with the main instance idle.
   task automatic step2(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                        input logic eStall, input logic eDone, input logic [15:0] eData);
      rd2 = r; wr2 = w; addr2 = a; din2 = d;
      drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      #3;
      check("lat2_stall",   16'(stall2), 16'(eStall));
      check("lat2_done",    16'(done2),  16'(eDone));
      check("lat2_dataOut", dataOut2,    eData);
      endCycle();
   endtask

   initial begin
      logic [15:0] inOrder [4];
      logic        r, w, rs;
      logic [15:0] a, d;
      logic [10:0] idx;
      int          sel;

      inOrder[0] = 16'h1111; inOrder[1] = 16'h2222;
      inOrder[2] = 16'h3333; inOrder[3] = 16'h4444;

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      k = 0;
      errPend = 1'b0;
      lastStall = 1'b0;
      for (int i = 0; i < 4; i++) bankFree[i] = 0;

      // Reset state
      drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      #3;
      check("rst_busy",    16'(busy), 16'h0000);
      check("rst_done",    16'(done), 16'h0000);
      check("rst_dataOut", dataOut,   16'h0000);
      check("rst_err",     16'(err),  16'h0000);
      endCycle();

      // Single write then read
      step(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
      idle(3);
      drive(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
      #3;
      check("wr_done",    16'(done), 16'h0001);
      check("wr_dataOut", dataOut,   16'h0000);
      endCycle();
      idle(3);
      drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      #3;
      check("rd_done",    16'(done), 16'h0001);
      check("rd_dataOut", dataOut,   16'hBEEF);
      endCycle();

      // Preload words used below
      issue(1'b0, 1'b1, 16'h0000, 16'h1111);
      issue(1'b0, 1'b1, 16'h0002, 16'h2222);
      issue(1'b0, 1'b1, 16'h0004, 16'h3333);
      issue(1'b0, 1'b1, 16'h0006, 16'h4444);
      issue(1'b0, 1'b1, 16'h0008, 16'h5555);
      idle(LAT);

      // Bank conflict on bank 0
      step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
      for (int i = 1; i <= 3; i++) begin
         drive(1'b1, 1'b0, 16'h0008, 16'h0000, 1'b0);
         #3;
         check("conf_stall", 16'(stall), 16'h0001);
         endCycle();
      end
      drive(1'b1, 1'b0, 16'h0008, 16'h0000, 1'b0);
      #3;
      check("conf_release", 16'(stall), 16'h0000);
      check("conf_done1",   16'(done),  16'h0001);
      check("conf_data1",   dataOut,    16'h1111);
      endCycle();
      idle(3);
      drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      #3;
      check("conf_done2", 16'(done), 16'h0001);
      check("conf_data2", dataOut,   16'h5555);
      endCycle();

      // Bank interleave: one accept per cycle, completions in order
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'(2 * i), 16'h0000, 1'b0);
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
         #3;
         check("ilv_done", 16'(done), 16'h0001);
         check("ilv_data", dataOut,   inOrder[i]);
         endCycle();
      end

      // Reset mid-flight drops the read
      step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
      idle(1);
      step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
      drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      #3;
      check("rstmid_busy", 16'(busy), 16'h0000);
      endCycle();
      drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      #3;
      check("rstmid_done", 16'(done), 16'h0000);
      endCycle();

      // A write presented while rst is high must not land
      step(1'b0, 1'b1, 16'h0002, 16'hDEAD, 1'b1);
      issue(1'b1, 1'b0, 16'h0002, 16'h0000);
      idle(LAT);

      // Odd address and Rd&Wr
      step(1'b1, 1'b0, 16'h0011, 16'h0000, 1'b0);
      idle(LAT - 1);
      drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      #3;
`ifdef MEM_ALIGN_CHECK_EN
      check("odd_done", 16'(done), 16'h0000);
`else
      check("odd_done", 16'(done), 16'h0001);
      check("odd_data", dataOut,   16'hBEEF);
`endif
      endCycle();
      step(1'b1, 1'b1, 16'h0004, 16'h9999, 1'b0);
      idle(LAT + 1);

      // Random traffic over a preloaded 16-word pool
      for (int i = 0; i < 16; i++) begin
         idx = (i / 4 == 3) ? 11'h7FF : 11'(i / 4);
         issue(1'b0, 1'b1, {2'b00, idx, 2'(i % 4), 1'b0}, 16'($urandom));
      end
      r = 1'b0; w = 1'b0; a = '0; d = '0; rs = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!lastStall) begin
            sel = int'($urandom_range(0, 9));
            r   = (sel <= 3) || (sel == 8);
            w   = (sel >= 4 && sel <= 7) || (sel == 8);
            sel = int'($urandom_range(0, 3));
            idx = (sel == 3) ? 11'h7FF : 11'(sel);
            a   = {2'($urandom_range(0, 3)), idx, 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1))};
            d   = 16'($urandom);
            rs  = ($urandom_range(0, 99) == 0);
         end else begin
            rs = 1'b0;
         end
         step(r, w, a, d, rs);
      end
      idle(LAT + 1);

      // BANK_LAT = 2 instance: back-to-back on one bank
      step2(1'b0, 1'b1, 16'h0000, 16'h1111, 1'b0, 1'b0, 16'h0000);
      step2(1'b0, 1'b1, 16'h0008, 16'h2222, 1'b1, 1'b0, 16'h0000);
      step2(1'b0, 1'b1, 16'h0008, 16'h2222, 1'b0, 1'b1, 16'h0000);
      step2(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
      step2(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000);
      step2(1'b1, 1'b0, 16'h0008, 16'h0000, 1'b1, 1'b0, 16'h0000);
      step2(1'b1, 1'b0, 16'h0008, 16'h0000, 1'b0, 1'b1, 16'h1111);
      step2(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
      step2(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h2222);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule
